seq_restoring_div: RTL and testbench



---
 rtl/seq_restoring_div.sv | 142 ++++++++++++++
 tb/tb_seq_restoring_div.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock using a trial subtraction.
// Divide-by-zero takes a one-cycle shortcut straight to DONE.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; operands are captured on the accepting edge
//   CALC   | one restoring step per cycle, exactly WIDTH cycles
//   DONE   | one-cycle done pulse; results were registered on entry
module seq_restoring_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    // After every restoring step the partial remainder is below the divisor,
    // so its top bit is always zero; only the low WIDTH bits are stored and
    // the full WIDTH+1-bit value exists only as the shifted/trial operand.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        shifted = {r_q, q_q[WIDTH-1]};
        trial   = shifted - {1'b0, d_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH);
                    if (divisor != '0) begin
                        state_d = S_CALC;
                    end else begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div: expected results and done/busy
// timing are queued when an operation is issued and compared when done fires.
module tb_seq_restoring_div;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;
        int           dcyc;
    } exp_t;

    exp_t sb[$];

    int           n_tests = 0;
    int           n_fail  = 0;
    bit           mon_en  = 1'b0;
    logic [W-1:0] hold_q  = '0;
    logic [W-1:0] hold_r  = '0;
    logic         hold_z  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Issue an operation that the bench knows will be accepted on the next edge.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q    = (b == 0) ? {W{1'b1}} : W'(a / b);
        e.r    = (b == 0) ? a : W'(a % b);
        e.dbz  = (b == 0);
        e.acc  = cyc + 1;
        e.dcyc = cyc + ((b == 0) ? 1 : W + 1);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while (sb.size() > 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_q"}, quotient, 0);
        chk({tag, "_r"}, remainder, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
    endtask

    // Monitor: busy window, done timing/results, and result hold between dones.
    exp_t h;
    logic exp_busy;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = 1'b0;
            if (sb.size() > 0)
                exp_busy = (cyc >= sb[0].acc) && (cyc <= sb[0].dcyc);
            chk("busy", busy, exp_busy);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    h = sb.pop_front();
                    chk("done_cycle", cyc, h.dcyc);
                    chk("quotient", quotient, h.q);
                    chk("remainder", remainder, h.r);
                    chk("div_by_zero", div_by_zero, h.dbz);
                    hold_q = h.q;
                    hold_r = h.r;
                    hold_z = h.dbz;
                end
            end else begin
                chk("hold_q", quotient, hold_q);
                chk("hold_r", remainder, hold_r);
                chk("hold_dbz", div_by_zero, hold_z);
            end
        end
    end

    logic [W-1:0] edge_a [5] = '{4'd15, 4'd2, 4'd0, 4'd15, 4'd13};
    logic [W-1:0] edge_b [5] = '{4'd1,  4'd9, 4'd5, 4'd15, 4'd3};

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // basic and edge values
        for (int i = 0; i < 5; i++) begin
            drive_op(edge_a[i], edge_b[i]);
            @(negedge clk);
            start = 1'b0;
            wait_drain(20);
        end

        // divide by zero, then a normal divide clears the flag
        drive_op(4'd7, 4'd0);
        @(negedge clk);
        start = 1'b0;
        wait_drain(20);
        drive_op(4'd6, 4'd2);
        @(negedge clk);
        start = 1'b0;
        wait_drain(20);

        // start while busy is ignored
        drive_op(4'd13, 4'd3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(20);
        repeat (6) @(negedge clk);

        // reset in the third CALC cycle aborts without a done pulse
        drive_op(4'd14, 4'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        hold_q = '0;
        hold_r = '0;
        hold_z = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        drive_op(4'd14, 4'd4);
        @(negedge clk);
        start = 1'b0;
        wait_drain(20);

        // exhaustive sweep, start held high, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive_op(W'(a), W'(b));
                repeat ((b == 0) ? 2 : W + 2) @(negedge clk);
            end
        end
        start = 1'b0;
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
